alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
- Issue/writeback sequencer in front of the ALU and its pipelined 16x16 multiplier.
- Single-cycle ALU ops are accepted every cycle and committed one cycle later.
- MULT stalls the decode stage, holds multiplier enable for the pipeline latency, then writes the 32-bit product to two registers over two cycles (low half to rd, high half to rd+1).
- Sits between decode (IR') and the register file / status register write ports.

Parameters:
- MULT_LAT, 3, cycles from mult_en assertion until the product is valid on prod_lo/prod_hi.
- DW, 16, datapath width.
- AW, 3, register address width.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an ALU instruction this cycle.
- issue_ready  out  1  sequencer accepts the instruction; decode stalls when low.
- issue_is_mult  in  1  the issued instruction is MULT.
- issue_rd  in  AW  destination register.
- issue_wr  in  1  the instruction writes rd (clear for ghost ops, jumps, stores).
- issue_sr_wr  in  1  the instruction updates the status register.
- flush  in  1  branch/jump taken; kills any in-flight op.
- alu_res  in  DW  ALU primary result (aluout1).
- alu_sr  in  8  ALU status output.
- prod_lo  in  DW  multiplier low half.
- prod_hi  in  DW  multiplier high half.
- mult_en  out  1  multiplier enable.
- rf_we  out  1  register file write enable.
- rf_waddr  out  AW  write address.
- rf_wdata  out  DW  write data.
- sr_we  out  1  status register write enable.
- sr_wdata  out  8  status register write data.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE, lat_cnt=0, and every output is 0, except issue_ready=1 once reset is released. All outputs are registered except issue_ready, which is a combinational decode of state.
- IDLE, issue_ready=1:
  - issue_valid & !is_mult & !flush: next cycle rf_we=issue_wr, rf_waddr=issue_rd, rf_wdata=alu_res (captured at issue), sr_we=issue_sr_wr, sr_wdata=alu_sr. Latency is 1 and back-to-back issue is allowed.
  - issue_valid & is_mult & !flush: latch rd and sr_wr, assert mult_en, lat_cnt=MULT_LAT-1, go to MWAIT.
- MWAIT, issue_ready=0:
  - mult_en=1 and lat_cnt decrements each cycle.
  - When lat_cnt==0, capture prod_lo/prod_hi into internal registers and go to WB_LO.
- WB_LO, issue_ready=0:
  - rf_we=1, rf_waddr=rd, rf_wdata=lo.
  - sr_we=latched sr_wr, with sr_wdata Z=(prod==0), N=prod_hi[15], other bits from alu_sr captured at issue.
  - Go to WB_HI.
- WB_HI, issue_ready=1:
  - rf_we=1, rf_waddr=(rd+1) mod 2^AW (so rd=7 wraps to 0), rf_wdata=hi, sr_we=0.
  - A new issue may be accepted in the same cycle and is handled exactly as from IDLE. Next state is IDLE or MWAIT.
- flush:
  - In IDLE or WB_HI, flush suppresses acceptance of that cycle's issue (no write results).
  - In MWAIT, flush returns to IDLE next cycle with mult_en=0 and no writeback.
  - In WB_LO, flush is ignored; the commit completes through WB_HI.
- flush and issue_valid in the same cycle: flush wins.
- rf_we/sr_we are single-cycle pulses. No write is generated when issue_wr=0.
- MULT_LAT=1: MWAIT lasts exactly one cycle.
- Reset mid-MWAIT or mid-WB: all state and outputs clear immediately; the partial product is never written.

Decomposition:
- Shared package (cpu_pkg): state enum {IDLE, MWAIT, WB_LO, WB_HI}, status-bit index constants (Z=0, N=1, C=2, T=3, V=4, S=5, I=7), and DW/AW defaults.
- One sub-module, mult_lat_counter: a down-counter with load/zero flag, reusable for other multi-cycle units.

Test Plan:
- Reset released, then ADD issued (rd=2, alu_res=16'h1234, issue_wr=1): one cycle later rf_we=1, rf_waddr=2, rf_wdata=16'h1234; issue_ready stays 1.
- MULT rd=3, MULT_LAT=3, prod=32'h0001_FFFE:
  - issue_ready=0 for 4 cycles and mult_en=1 for 3 cycles.
  - Then write (3, 16'hFFFE) followed by write (4, 16'h0001).
  - sr_wdata Z=0, N=0.
- MULT rd=7, prod=32'h8000_0000: writes go to (7, 16'h0000) then (0, 16'h8000); N=1, Z=0.
- MULT followed by flush on the 2nd MWAIT cycle: no rf_we at all; state is IDLE on the next cycle; mult_en drops.
- Back-to-back MULT issued during WB_HI: accepted in that cycle; mult_en rises the next cycle with no bubble; the second pair of writes follows correctly.
- RESET_N asserted during WB_LO: outputs go to 0 asynchronously; after release the first ADD commits normally with no stale high-half write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, status-register bit positions and datapath defaults.
package cpu_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 3;

  localparam int unsigned SR_Z = 0;
  localparam int unsigned SR_N = 1;
  localparam int unsigned SR_C = 2;
  localparam int unsigned SR_T = 3;
  localparam int unsigned SR_V = 4;
  localparam int unsigned SR_S = 5;
  localparam int unsigned SR_I = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MWAIT = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

endpackage

// File: rtl/mult_lat_counter.sv
// Loadable down-counter with zero flag for timing fixed-latency multi-cycle units.
module mult_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // Saturates at zero so a stray decrement cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/alu_mult_seq.sv
// Issue/writeback sequencer: single-cycle ALU commits, and MULT stall plus two-cycle product
// writeback (low half to rd, high half to rd+1).
module alu_mult_seq
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          issue_is_mult,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_wr,
  input  logic          issue_sr_wr,
  input  logic          flush,
  input  logic [DW-1:0] alu_res,
  input  logic [7:0]    alu_sr,
  input  logic [DW-1:0] prod_lo,
  input  logic [DW-1:0] prod_hi,
  output logic          mult_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          sr_we,
  output logic [7:0]    sr_wdata,
  output logic          busy
);

  localparam int unsigned CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_t        state;
  logic [AW-1:0] rd_q;
  logic          sr_wr_q;
  logic [7:0]    sr_q;
  logic [DW-1:0] hi_q;
  logic [CW-1:0] lat_cnt;
  logic          lat_zero;
  logic          accept;
  logic [7:0]    mult_sr;

  // Held low during reset so decode never sees a ready sequencer before release.
  assign issue_ready = RESET_N && ((state == IDLE) || (state == WB_HI));
  assign accept      = issue_valid && issue_ready && !flush;

  always_comb begin
    mult_sr       = sr_q;
    mult_sr[SR_Z] = (prod_lo == '0) && (prod_hi == '0);
    mult_sr[SR_N] = prod_hi[DW-1];
  end

  mult_lat_counter #(
    .W (CW)
  ) u_lat_cnt (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .load     (accept && issue_is_mult),
    .load_val (CW'(MULT_LAT - 1)),
    .dec      (state == MWAIT),
    .count    (lat_cnt),
    .zero     (lat_zero)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      rd_q     <= '0;
      sr_wr_q  <= 1'b0;
      sr_q     <= '0;
      hi_q     <= '0;
      mult_en  <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sr_we    <= 1'b0;
      sr_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      sr_we <= 1'b0;
      unique case (state)
        IDLE, WB_HI: begin
          if (accept && issue_is_mult) begin
            rd_q    <= issue_rd;
            sr_wr_q <= issue_sr_wr;
            sr_q    <= alu_sr;
            mult_en <= 1'b1;
            state   <= MWAIT;
            busy    <= 1'b1;
          end else begin
            if (accept) begin
              rf_we    <= issue_wr;
              rf_waddr <= issue_rd;
              rf_wdata <= alu_res;
              sr_we    <= issue_sr_wr;
              sr_wdata <= alu_sr;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MWAIT: begin
          if (flush) begin
            mult_en <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (lat_zero) begin
            // Product is valid now: commit the low half and flags, keep the high half.
            mult_en  <= 1'b0;
            hi_q     <= prod_hi;
            rf_we    <= 1'b1;
            rf_waddr <= rd_q;
            rf_wdata <= prod_lo;
            sr_we    <= sr_wr_q;
            sr_wdata <= mult_sr;
            state    <= WB_LO;
          end
        end
        WB_LO: begin
          rf_we    <= 1'b1;
          rf_waddr <= rd_q + AW'(1);
          rf_wdata <= hi_q;
          state    <= WB_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq: ALU commit, MULT writeback, wrap, flush, back-to-back, reset.
module tb_alu_mult_seq;

  logic        CLOCK;
  logic        RESET_N;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_is_mult;
  logic [2:0]  issue_rd;
  logic        issue_wr;
  logic        issue_sr_wr;
  logic        flush;
  logic [15:0] alu_res;
  logic [7:0]  alu_sr;
  logic [15:0] prod_lo;
  logic [15:0] prod_hi;
  logic        mult_en;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        sr_we;
  logic [7:0]  sr_wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_mult_seq #(
    .MULT_LAT (3),
    .DW       (16),
    .AW       (3)
  ) dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_is_mult (issue_is_mult),
    .issue_rd      (issue_rd),
    .issue_wr      (issue_wr),
    .issue_sr_wr   (issue_sr_wr),
    .flush         (flush),
    .alu_res       (alu_res),
    .alu_sr        (alu_sr),
    .prod_lo       (prod_lo),
    .prod_hi       (prod_hi),
    .mult_en       (mult_en),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .sr_we         (sr_we),
    .sr_wdata      (sr_wdata),
    .busy          (busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'd1);
    chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
  endtask

  task automatic issue_mult(input logic [2:0] rd, input logic [7:0] sr);
    issue_valid   = 1'b1;
    issue_is_mult = 1'b1;
    issue_rd      = rd;
    issue_wr      = 1'b1;
    issue_sr_wr   = 1'b1;
    alu_sr        = sr;
    step();
    issue_valid   = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; issue_valid = 1'b0; issue_is_mult = 1'b0; issue_rd = '0;
    issue_wr = 1'b0; issue_sr_wr = 1'b0; flush = 1'b0; alu_res = '0; alu_sr = '0;
    prod_lo = '0; prod_hi = '0;
    #2;
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.mult_en", 32'(mult_en), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.sr_we", 32'(sr_we), 32'd0);
    chk("rst.ready", 32'(issue_ready), 32'd0);
    step(); step();
    RESET_N = 1'b1;
    #1;
    chk("rel.ready", 32'(issue_ready), 32'd1);

    // ADD rd=2
    issue_valid = 1'b1; issue_is_mult = 1'b0; issue_rd = 3'd2; issue_wr = 1'b1;
    issue_sr_wr = 1'b1; alu_res = 16'h1234; alu_sr = 8'h05;
    step();
    issue_valid = 1'b0;
    chk_wr("add", 3'd2, 16'h1234);
    chk("add.sr_we", 32'(sr_we), 32'd1);
    chk("add.sr", 32'(sr_wdata), 32'h05);
    chk("add.ready", 32'(issue_ready), 32'd1);
    step();
    chk("add.pulse", 32'(rf_we), 32'd0);

    // MULT rd=3, prod=0001_FFFE
    prod_hi = 16'h0001; prod_lo = 16'hFFFE;
    issue_mult(3'd3, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      chk("m1.mult_en", 32'(mult_en), 32'd1);
      chk("m1.ready", 32'(issue_ready), 32'd0);
      chk("m1.nowr", 32'(rf_we), 32'd0);
      step();
    end
    chk("m1.en_drop", 32'(mult_en), 32'd0);
    chk("m1.lo_ready", 32'(issue_ready), 32'd0);
    chk_wr("m1.lo", 3'd3, 16'hFFFE);
    chk("m1.sr_we", 32'(sr_we), 32'd1);
    chk("m1.sr", 32'(sr_wdata), 32'hF0);
    step();
    chk_wr("m1.hi", 3'd4, 16'h0001);
    chk("m1.hi_sr_we", 32'(sr_we), 32'd0);
    chk("m1.hi_ready", 32'(issue_ready), 32'd1);
    step();
    chk("m1.idle_we", 32'(rf_we), 32'd0);
    chk("m1.idle_busy", 32'(busy), 32'd0);

    // MULT rd=7, prod=8000_0000: high half wraps to r0, N=1, incoming Z cleared
    prod_hi = 16'h8000; prod_lo = 16'h0000;
    issue_mult(3'd7, 8'h01);
    step(); step(); step();
    chk_wr("m2.lo", 3'd7, 16'h0000);
    chk("m2.sr", 32'(sr_wdata), 32'h02);
    step();
    chk_wr("m2.hi", 3'd0, 16'h8000);
    step();

    // MULT flushed in second MWAIT cycle
    issue_mult(3'd5, 8'h00);
    step();
    chk("fl.mwait2_en", 32'(mult_en), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl.en", 32'(mult_en), 32'd0);
    chk("fl.busy", 32'(busy), 32'd0);
    chk("fl.ready", 32'(issue_ready), 32'd1);
    chk("fl.we0", 32'(rf_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl.no_we", 32'(rf_we), 32'd0);
    end

    // flush beats issue_valid in IDLE
    issue_valid = 1'b1; issue_is_mult = 1'b0; issue_rd = 3'd1; alu_res = 16'hAAAA;
    flush = 1'b1;
    step();
    issue_valid = 1'b0; flush = 1'b0;
    chk("fli.we", 32'(rf_we), 32'd0);
    chk("fli.sr_we", 32'(sr_we), 32'd0);

    // Back-to-back MULT accepted during WB_HI
    prod_hi = 16'h1234; prod_lo = 16'h5678;
    issue_mult(3'd1, 8'h00);
    step(); step(); step();
    chk_wr("bb.lo1", 3'd1, 16'h5678);
    issue_valid = 1'b1; issue_is_mult = 1'b1; issue_rd = 3'd6; issue_sr_wr = 1'b1;
    alu_sr = 8'h00;
    step();
    chk_wr("bb.hi1", 3'd2, 16'h1234);
    chk("bb.ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0;
    chk("bb.en_nobubble", 32'(mult_en), 32'd1);
    chk("bb.busy", 32'(busy), 32'd1);
    prod_hi = 16'h0000; prod_lo = 16'h0000;
    step(); step(); step();
    chk_wr("bb.lo2", 3'd6, 16'h0000);
    chk("bb.sr2", 32'(sr_wdata), 32'h01);
    step();
    chk_wr("bb.hi2", 3'd7, 16'h0000);
    step();

    // Reset asserted during WB_LO
    prod_hi = 16'hABCD; prod_lo = 16'h0123;
    issue_mult(3'd2, 8'h00);
    step(); step(); step();
    chk_wr("rs.lo", 3'd2, 16'h0123);
    #1 RESET_N = 1'b0;
    #1;
    chk("rs.we", 32'(rf_we), 32'd0);
    chk("rs.data", 32'(rf_wdata), 32'd0);
    chk("rs.sr_we", 32'(sr_we), 32'd0);
    chk("rs.busy", 32'(busy), 32'd0);
    step();
    RESET_N = 1'b1;
    #1;
    chk("rs.rel_we", 32'(rf_we), 32'd0);
    issue_valid = 1'b1; issue_is_mult = 1'b0; issue_rd = 3'd4; issue_wr = 1'b1;
    alu_res = 16'hBEEF;
    step();
    issue_valid = 1'b0;
    chk_wr("rs.add", 3'd4, 16'hBEEF);
    step();
    chk("rs.no_stale", 32'(rf_we), 32'd0);

    // ADD with issue_wr=0 produces no register write
    issue_valid = 1'b1; issue_wr = 1'b0; issue_sr_wr = 1'b0; issue_rd = 3'd5;
    step();
    issue_valid = 1'b0;
    chk("ghost.we", 32'(rf_we), 32'd0);
    chk("ghost.sr_we", 32'(sr_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
